// File: rtl/sub_pkg.sv
// sub_pkg
//   Shared definitions for the serial subtract path.
//   - DEF_WIDTH / DEF_SLICE : default operand width and bits handled per clock
//   - state_t               : control states of the serial subtractor
package sub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_slice.sv
// csa_slice
//   Combinational SLICE-bit carry-select adder. Two ripple chains run in
//   parallel, one assuming carry-in 0 and one assuming carry-in 1; the real
//   carry-in then only has to drive the final select.
// Ports
//   a, b  in   SLICE  addends
//   cin   in   1      carry into the slice
//   sum   out  SLICE  a + b + cin (low SLICE bits)
//   cout  out  1      carry out of the slice
module csa_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0]   c0;
  logic [SLICE:0]   c1;
  logic [SLICE-1:0] s0;
  logic [SLICE-1:0] s1;

  // Both speculative ripple chains, built bit by bit.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < SLICE; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // A carry out with cin=0 implies one with cin=1, so c0 alone decides when set.
  assign sum  = cin ? s1 : s0;
  assign cout = c0[SLICE] | (c1[SLICE] & cin);

endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   Multi-cycle WIDTH-bit two's-complement subtractor computing A - B one
//   SLICE-bit slice per clock through a single carry-select slice. The
//   subtraction is done as A + ~B + 1, with the +1 seeded into the carry reg.
// Ports
//   Clk       in   1      rising-edge clock
//   Reset     in   1      asynchronous active-high reset, clears everything
//   Start     in   1      operation request, looked at only while idle
//   A, B      in   WIDTH  minuend / subtrahend, captured when Start is accepted
//   Busy      out  1      high while an operation is running or completing
//   Done      out  1      one-cycle pulse when results are valid
//   Diff      out  WIDTH  A - B modulo 2^WIDTH, held until the next Done
//   Borrow    out  1      set when unsigned A < B
//   Overflow  out  1      signed overflow of A - B
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sign_a;
  logic             sign_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             last_slice;

  csa_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (op_a[SLICE-1:0]),
    .b    (op_b[SLICE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (cnt == LAST_CNT);

  // New slice enters at the top so after NSLICES shifts the LSB slice sits at the bottom.
  assign result_next = (result >> SLICE) | (WIDTH'(slice_sum) << (WIDTH - SLICE));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Busy and Done decode only the state register so Start never reaches them combinationally.
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, carry chain and result outputs. Diff only updates on the
  // final slice so partial sums stay internal.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      Diff     <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_a   <= A;
            op_b   <= ~B;
            carry  <= 1'b1;
            cnt    <= '0;
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
          end
        end
        RUN: begin
          op_a   <= op_a >> SLICE;
          op_b   <= op_b >> SLICE;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          result <= result_next;
          if (last_slice) begin
            Diff     <= result_next;
            Borrow   <= ~slice_cout;
            Overflow <= (sign_a != sign_b) && (result_next[WIDTH-1] != sign_a);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor
//   Directed and random checks of the serial subtractor at WIDTH=16, SLICE=4.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nibble_serial_subtractor;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Busy;
  logic        Done;
  logic [15:0] Diff;
  logic        Borrow;
  logic        Overflow;

  int errors = 0;
  int checks = 0;

  // Counting the cycle in which Start is presented as cycle 1, Done is high in
  // cycle 6, i.e. on the 5th falling edge after the one that presented Start.
  localparam int DONE_LAT = 5;

  nibble_serial_subtractor #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Diff     (Diff),
    .Borrow   (Borrow),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Presents one operation and waits (bounded) for Done; lat is -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge Clk);
    A     = a;
    B     = b;
    Start = 1'b1;
    lat   = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat;
    run_op(16'h0001, 16'h0002, lat);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
    checks++; if (Diff !== 16'h0000) begin errors++; $display("[TB] FAIL reset_diff: got %h expected 0000", Diff); end
    checks++; if (Borrow !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow: got %b expected 0", Borrow); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", Overflow); end
    @(negedge Clk);
    Reset = 1'b0;
    run_op(16'h0005, 16'h0003, lat);
    checks++; if (lat !== DONE_LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, DONE_LAT); end
    checks++; if (Diff !== 16'h0002) begin errors++; $display("[TB] FAIL basic_diff: got %h expected 0002", Diff); end
    checks++; if (Borrow !== 1'b0) begin errors++; $display("[TB] FAIL basic_borrow: got %b expected 0", Borrow); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow: got %b expected 0", Overflow); end
  endtask

  task automatic test_borrow;
    int lat;
    run_op(16'h0000, 16'h0001, lat);
    checks++; if (Diff !== 16'hFFFF) begin errors++; $display("[TB] FAIL borrow_diff: got %h expected FFFF", Diff); end
    checks++; if (Borrow !== 1'b1) begin errors++; $display("[TB] FAIL borrow_flag: got %b expected 1", Borrow); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL borrow_overflow: got %b expected 0", Overflow); end
  endtask

  task automatic test_overflow;
    int lat;
    run_op(16'h8000, 16'h0001, lat);
    checks++; if (Diff !== 16'h7FFF) begin errors++; $display("[TB] FAIL ovf1_diff: got %h expected 7FFF", Diff); end
    checks++; if (Borrow !== 1'b0) begin errors++; $display("[TB] FAIL ovf1_borrow: got %b expected 0", Borrow); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf1_overflow: got %b expected 1", Overflow); end
    run_op(16'h7FFF, 16'hFFFF, lat);
    checks++; if (Diff !== 16'h8000) begin errors++; $display("[TB] FAIL ovf2_diff: got %h expected 8000", Diff); end
    checks++; if (Borrow !== 1'b1) begin errors++; $display("[TB] FAIL ovf2_borrow: got %b expected 1", Borrow); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf2_overflow: got %b expected 1", Overflow); end
  endtask

  // Diff still holds 8000 from the previous operation while this one runs.
  task automatic test_start_ignored;
    int          dones;
    logic [15:0] got_diff;
    logic        got_borrow;
    dones      = 0;
    got_diff   = 16'hxxxx;
    got_borrow = 1'bx;
    @(negedge Clk);
    A     = 16'h1234;
    B     = 16'h1234;
    Start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (c == 2) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL run_busy: got %b expected 1", Busy); end
        checks++; if (Diff !== 16'h8000) begin errors++; $display("[TB] FAIL run_diff_held: got %h expected 8000", Diff); end
        Start = 1'b1;
        A     = 16'hFFFF;
        B     = 16'h0001;
      end
      if (Done) begin
        dones++;
        got_diff   = Diff;
        got_borrow = Borrow;
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++; if (got_diff !== 16'h0000) begin errors++; $display("[TB] FAIL ignore_diff: got %h expected 0000", got_diff); end
    checks++; if (got_borrow !== 1'b0) begin errors++; $display("[TB] FAIL ignore_borrow: got %b expected 0", got_borrow); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int dones;
    run_op(16'h0000, 16'h0001, lat);
    @(negedge Clk);
    A     = 16'h0F0F;
    B     = 16'h0101;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", Busy); end
    checks++; if (Diff !== 16'h0000) begin errors++; $display("[TB] FAIL abort_diff: got %h expected 0000", Diff); end
    checks++; if (Borrow !== 1'b0) begin errors++; $display("[TB] FAIL abort_borrow: got %b expected 0", Borrow); end
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dones); end
    run_op(16'hABCD, 16'h0123, lat);
    checks++; if (lat !== DONE_LAT) begin errors++; $display("[TB] FAIL after_abort_latency: got %0d expected %0d", lat, DONE_LAT); end
    checks++; if (Diff !== 16'hAAAA) begin errors++; $display("[TB] FAIL after_abort_diff: got %h expected AAAA", Diff); end
    checks++; if (Borrow !== 1'b0) begin errors++; $display("[TB] FAIL after_abort_borrow: got %b expected 0", Borrow); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    int prev;
    ndone = 0;
    prev  = 0;
    @(negedge Clk);
    A     = 16'h0100;
    B     = 16'h0001;
    Start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (Done) begin
        ndone++;
        if (ndone > 1) begin
          checks++; if (c - prev !== 6) begin errors++; $display("[TB] FAIL b2b_interval: got %0d expected 6", c - prev); end
        end
        checks++; if (Diff !== 16'h00FF) begin errors++; $display("[TB] FAIL b2b_diff: got %h expected 00FF", Diff); end
        prev = c;
        if (ndone == 3) begin
          Start = 1'b0;
          break;
        end
      end
    end
    Start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", ndone); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_pulse: got %b expected 0", Done); end
  endtask

  task automatic test_random;
    int          lat;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] full;
    logic [15:0] exp_diff;
    logic        exp_borrow;
    logic        exp_ovf;
    for (int n = 0; n < 500; n++) begin
      a          = 16'($urandom);
      b          = 16'($urandom);
      full       = {1'b0, a} - {1'b0, b};
      exp_diff   = full[15:0];
      exp_borrow = (a < b);
      exp_ovf    = (a[15] != b[15]) && (exp_diff[15] != a[15]);
      run_op(a, b, lat);
      checks++; if (lat !== DONE_LAT) begin errors++; $display("[TB] FAIL rand_latency: %h-%h got %0d expected %0d", a, b, lat, DONE_LAT); end
      checks++; if (Diff !== exp_diff) begin errors++; $display("[TB] FAIL rand_diff: %h-%h got %h expected %h", a, b, Diff, exp_diff); end
      checks++; if (Borrow !== exp_borrow) begin errors++; $display("[TB] FAIL rand_borrow: %h-%h got %b expected %b", a, b, Borrow, exp_borrow); end
      checks++; if (Overflow !== exp_ovf) begin errors++; $display("[TB] FAIL rand_overflow: %h-%h got %b expected %b", a, b, Overflow, exp_ovf); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    A     = 16'h0000;
    B     = 16'h0000;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    test_reset();
    test_borrow();
    test_overflow();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
